dram_device_model: RTL and testbench

- Cycle-accurate, synthesizable model of the single-bank DRAM device that sits on the far side of the DRAM pin interface (CSn/RASn/CASn/WEn/A/D/Q/valid).
- It decodes ACTIVATE, READ, WRITE and PRECHARGE commands and holds one open row.
- Read data returns after a fixed latency with a one-cycle valid strobe; write bytes are selected by an active-low byte mask.
- It checks command ordering and row timing and flags violations. It is used in system simulation and in FPGA bring-up of the memory subsystem.

---
 rtl/dram_device_model.sv | 207 ++++++++++++++++++++
 tb/tb_dram_device_model.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_device_model.sv
// dram_device_model: cycle-accurate single-bank DRAM device behind the
// CSn/RASn/CASn/WEn/A/D/Q/valid pin interface. It decodes ACTIVATE, READ,
// WRITE and PRECHARGE, keeps one open row, returns read data after a fixed
// latency and pulses err_o on ordering or row-timing violations.
module dram_device_model #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 11,
    parameter int ROW_BITS  = 11,
    parameter int COL_BITS  = 10,
    parameter int READ_LAT  = 5,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CSn_i,
    input  logic                   RASn_i,
    input  logic                   CASn_i,
    input  logic [DATA_BITS/8-1:0] WEn_i,
    input  logic [ADDR_BITS-1:0]   A_i,
    input  logic [DATA_BITS-1:0]   D_i,
    output logic [DATA_BITS-1:0]   Q_o,
    output logic                   VALID_o,
    output logic                   err_o
);

    localparam int BYTES = DATA_BITS / 8;
    localparam int AW    = ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    // The timer only needs to count up to the larger of the two row timings.
    localparam int T_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int T_SAT = (T_MAX < 1) ? 1 : T_MAX;
    localparam int TW    = $clog2(T_SAT + 1);

    localparam logic [TW-1:0] SAT_TICKS = TW'(T_SAT);
    localparam logic [TW-1:0] RP_TICKS  = TW'(T_RP);
    localparam logic [TW-1:0] RCD_TICKS = TW'(T_RCD);

    // Elaboration-time guards on the parameter set.
    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
        $error("dram_device_model: READ_LAT=%0d outside 1..15", READ_LAT);
    end
    if (ROW_BITS > ADDR_BITS || COL_BITS > ADDR_BITS) begin : g_bad_addr
        $error("dram_device_model: ROW_BITS/COL_BITS wider than ADDR_BITS");
    end
    if (DATA_BITS % 8 != 0) begin : g_bad_data
        $error("dram_device_model: DATA_BITS must be a multiple of 8");
    end

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_RD,
        CMD_WR,
        CMD_ILL
    } cmd_e;

    typedef enum logic {
        ST_CLOSED,
        ST_OPEN
    } state_e;

    cmd_e                 cmd;
    state_e               state;
    state_e               state_next;
    logic                 err_next;
    logic                 row_load;
    logic                 timer_restart;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [TW-1:0]        timer;
    logic [ROW_BITS-1:0]  row;
    logic [AW-1:0]        addr;
    logic [DATA_BITS-1:0] mem [0:DEPTH-1];
    logic [READ_LAT-1:0]  pipe_v;
    logic [DATA_BITS-1:0] pipe_d [0:READ_LAT-1];

    // Column commands always address the currently open row.
    assign addr = {row, A_i[COL_BITS-1:0]};

    // Decode the pin levels into a single command for this cycle.
    always_comb begin
        cmd = CMD_NOP;
        if (!CSn_i) begin
            unique case ({RASn_i, CASn_i})
                2'b11: cmd = CMD_NOP;
                2'b00: cmd = CMD_ILL;
                2'b01: begin
                    if (&WEn_i)       cmd = CMD_ACT;
                    else if (~|WEn_i) cmd = CMD_PRE;
                    else              cmd = CMD_ILL;
                end
                2'b10: cmd = (&WEn_i) ? CMD_RD : CMD_WR;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Bank state register and the registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLOSED;
            err_o <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_next;
            err_o <= err_next;
        end
    end

    // Next-state, legality checks and per-command strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and a latch is never inferred.
        state_next    = state;
        err_next      = 1'b0;
        row_load      = 1'b0;
        timer_restart = 1'b0;
        wr_fire       = 1'b0;
        rd_fire       = 1'b0;
        if (!rst) begin
            unique case (cmd)
                CMD_ACT: begin
                    if (state == ST_CLOSED && timer >= RP_TICKS) begin
                        row_load      = 1'b1;
                        timer_restart = 1'b1;
                        state_next    = ST_OPEN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                CMD_PRE: begin
                    // Precharging an already closed bank is a harmless no-op.
                    if (state == ST_OPEN) begin
                        timer_restart = 1'b1;
                        state_next    = ST_CLOSED;
                    end
                end
                CMD_RD: begin
                    if (state == ST_OPEN && timer >= RCD_TICKS) rd_fire  = 1'b1;
                    else                                         err_next = 1'b1;
                end
                CMD_WR: begin
                    if (state == ST_OPEN && timer >= RCD_TICKS) wr_fire  = 1'b1;
                    else                                         err_next = 1'b1;
                end
                CMD_ILL: err_next = 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating cycles-since-ACTIVATE/PRECHARGE timer and the open-row latch.
    // The timer restarts at 1 so that, N edges after the command, it reads N.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= SAT_TICKS;
            row   <= '0;
        end else begin
            if (timer_restart)           timer <= TW'(1);
            else if (timer < SAT_TICKS)  timer <= timer + TW'(1);
            if (row_load) row <= A_i[ROW_BITS-1:0];
        end
    end

    // Storage array with active-low byte-lane write mask.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents must survive rst, and
        // resetting it would also block mapping onto block RAM.
        if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (!WEn_i[i]) mem[addr][8*i +: 8] <= D_i[8*i +: 8];
            end
        end
    end

    // Read-valid shift chain; reset flushes every pending read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= rd_fire;
            for (int i = 1; i < READ_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    // Read-data shift chain; the word is captured on the READ edge so a later
    // WRITE to the same address cannot leak into an in-flight read.
    always_ff @(posedge clk) begin
        pipe_d[0] <= mem[addr];
        for (int i = 1; i < READ_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end

    // Output register: Q_o updates only with VALID_o and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q_o     <= '0;
            VALID_o <= 1'b0;
        end else begin
            VALID_o <= pipe_v[READ_LAT-1];
            if (pipe_v[READ_LAT-1]) Q_o <= pipe_d[READ_LAT-1];
        end
    end

endmodule

// File: tb/tb_dram_device_model.sv
// Self-checking bench for dram_device_model: a cycle-by-cycle command table
// with hand-computed err_o/VALID_o/Q_o expectations, plus a hand-written
// reset-during-read sequence.
module tb_dram_device_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        CSn_i;
    logic        RASn_i;
    logic        CASn_i;
    logic [3:0]  WEn_i;
    logic [10:0] A_i;
    logic [31:0] D_i;
    logic [31:0] Q_o;
    logic        VALID_o;
    logic        err_o;

    int tests  = 0;
    int failed = 0;

    typedef enum int {K_NOP, K_ACT, K_PRE, K_RD, K_WR, K_ILL, K_ILL2, K_DES} kind_e;

    typedef struct {
        kind_e       kind;
        logic [10:0] a;
        logic [3:0]  wen;
        logic [31:0] d;
        logic        e_err;
        logic        e_valid;
        logic        chk_q;
        logic [31:0] e_q;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dram_device_model dut (
        .clk     (clk),
        .rst     (rst),
        .CSn_i   (CSn_i),
        .RASn_i  (RASn_i),
        .CASn_i  (CASn_i),
        .WEn_i   (WEn_i),
        .A_i     (A_i),
        .D_i     (D_i),
        .Q_o     (Q_o),
        .VALID_o (VALID_o),
        .err_o   (err_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input kind_e k, input logic [10:0] a, input logic [3:0] wen,
                         input logic [31:0] d);
        CSn_i  = 1'b0;
        RASn_i = 1'b1;
        CASn_i = 1'b1;
        WEn_i  = 4'hF;
        A_i    = a;
        D_i    = d;
        case (k)
            K_ACT:  RASn_i = 1'b0;
            K_PRE:  begin RASn_i = 1'b0; WEn_i = 4'h0; end
            K_RD:   CASn_i = 1'b0;
            K_WR:   begin CASn_i = 1'b0; WEn_i = wen; end
            K_ILL:  begin RASn_i = 1'b0; CASn_i = 1'b0; end
            K_ILL2: begin RASn_i = 1'b0; WEn_i = 4'b0101; end
            K_DES:  begin CSn_i = 1'b1; RASn_i = 1'b0; CASn_i = 1'b0; end
            default: ;
        endcase
    endtask

    // Table builders: a command with its expected err_o, NOP gaps, and NOPs
    // on which a read result (or a held Q_o) is expected.
    task automatic a_cmd(input kind_e k, input int a, input logic [3:0] wen,
                         input logic [31:0] d, input logic e_err);
        vecs.push_back('{k, 11'(a), wen, d, e_err, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic a_nop(input int n);
        for (int i = 0; i < n; i++)
            vecs.push_back('{K_NOP, 11'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic a_val(input logic [31:0] q);
        vecs.push_back('{K_NOP, 11'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, q});
    endtask

    task automatic a_hold(input logic [31:0] q);
        vecs.push_back('{K_NOP, 11'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, q});
    endtask

    initial begin
        // ---- stimulus table, one entry per clock (cycle index in comments) ----
        // Write then read back a full word in row 3.
        a_cmd(K_ACT, 3, 4'hF, 0, 0);                 // c0
        a_nop(4);                                    // c1-4
        a_cmd(K_WR, 7, 4'h0, 32'hDEADBEEF, 0);       // c5
        a_nop(4);                                    // c6-9
        a_cmd(K_RD, 7, 4'hF, 0, 0);                  // c10
        a_nop(4);                                    // c11-14
        a_val(32'hDEADBEEF);                         // c15
        a_hold(32'hDEADBEEF);                        // c16
        // Byte-masked writes; the WRITE after the first READ must not leak in.
        a_cmd(K_WR, 8, 4'h0, 32'h11223344, 0);       // c17
        a_cmd(K_WR, 8, 4'b1110, 32'h000000AA, 0);    // c18
        a_cmd(K_RD, 8, 4'hF, 0, 0);                  // c19
        a_cmd(K_WR, 8, 4'b0011, 32'h55660000, 0);    // c20
        a_cmd(K_RD, 8, 4'hF, 0, 0);                  // c21
        a_nop(2);                                    // c22-23
        a_val(32'h112233AA);                         // c24
        a_hold(32'h112233AA);                        // c25
        a_val(32'h556633AA);                         // c26
        // ACTIVATE while open is rejected; row 3 keeps serving reads.
        a_cmd(K_ACT, 9, 4'hF, 0, 1);                 // c27
        a_cmd(K_RD, 7, 4'hF, 0, 0);                  // c28
        a_nop(4);                                    // c29-32
        a_val(32'hDEADBEEF);                         // c33
        // Back-to-back reads return in order on consecutive cycles.
        a_cmd(K_WR, 0, 4'h0, 32'h000000A0, 0);       // c34
        a_cmd(K_WR, 1, 4'h0, 32'h000000A1, 0);       // c35
        a_cmd(K_WR, 2, 4'h0, 32'h000000A2, 0);       // c36
        a_cmd(K_RD, 0, 4'hF, 0, 0);                  // c37
        a_cmd(K_RD, 1, 4'hF, 0, 0);                  // c38
        a_cmd(K_RD, 2, 4'hF, 0, 0);                  // c39
        a_nop(2);                                    // c40-41
        a_val(32'h000000A0);                         // c42
        a_val(32'h000000A1);                         // c43
        a_val(32'h000000A2);                         // c44
        a_hold(32'h000000A2);                        // c45
        // tRP: ACTIVATE 4 cycles after PRECHARGE fails, 5 cycles succeeds.
        a_cmd(K_PRE, 0, 4'hF, 0, 0);                 // c46
        a_nop(3);                                    // c47-49
        a_cmd(K_ACT, 1, 4'hF, 0, 1);                 // c50
        a_cmd(K_ACT, 3, 4'hF, 0, 0);                 // c51
        // tRCD: READ 3 cycles after ACTIVATE fails, 5 cycles succeeds.
        a_nop(2);                                    // c52-53
        a_cmd(K_RD, 7, 4'hF, 0, 1);                  // c54
        a_nop(1);                                    // c55
        a_cmd(K_RD, 7, 4'hF, 0, 0);                  // c56
        a_nop(4);                                    // c57-60
        a_val(32'hDEADBEEF);                         // c61
        // Closed bank: PRECHARGE is legal, READ/WRITE are dropped with err.
        a_cmd(K_PRE, 0, 4'hF, 0, 0);                 // c62
        a_cmd(K_PRE, 0, 4'hF, 0, 0);                 // c63
        a_cmd(K_RD, 7, 4'hF, 0, 1);                  // c64
        a_cmd(K_WR, 7, 4'h0, 32'h00000000, 1);       // c65
        a_nop(3);                                    // c66-68
        a_cmd(K_ACT, 3, 4'hF, 0, 0);                 // c69
        a_nop(4);                                    // c70-73
        a_cmd(K_RD, 7, 4'hF, 0, 0);                  // c74
        a_nop(4);                                    // c75-78
        a_val(32'hDEADBEEF);                         // c79
        // Deselect is ignored; illegal encodings pulse err and change nothing.
        a_cmd(K_DES, 0, 4'hF, 0, 0);                 // c80
        a_cmd(K_ILL, 0, 4'hF, 0, 1);                 // c81
        a_cmd(K_ILL2, 0, 4'hF, 0, 1);                // c82
        a_cmd(K_RD, 0, 4'hF, 0, 0);                  // c83
        a_nop(4);                                    // c84-87
        a_val(32'h000000A0);                         // c88

        // ---- reset; an ACTIVATE presented during reset must be ignored ----
        rst = 1'b1;
        drive(K_NOP, 0, 4'hF, 0);
        step();
        drive(K_ACT, 5, 4'hF, 0);
        step();
        check("reset Q_o", Q_o, 32'h0);
        check("reset VALID_o", 32'(VALID_o), 32'h0);
        check("reset err_o", 32'(err_o), 32'h0);
        rst = 1'b0;

        // ---- table-driven run ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].kind, vecs[i].a, vecs[i].wen, vecs[i].d);
            step();
            check($sformatf("c%0d err_o", i), 32'(err_o), 32'(vecs[i].e_err));
            check($sformatf("c%0d VALID_o", i), 32'(VALID_o), 32'(vecs[i].e_valid));
            if (vecs[i].chk_q) check($sformatf("c%0d Q_o", i), Q_o, vecs[i].e_q);
        end

        // ---- reset two cycles after a READ flushes it ----
        drive(K_RD, 1, 4'hF, 0);
        step();
        drive(K_NOP, 0, 4'hF, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("flush Q_o", Q_o, 32'h0);
        check("flush err_o", 32'(err_o), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("flush VALID_o +%0d", i), 32'(VALID_o), 32'h0);
        end
        // Bank is closed after reset, so a READ is rejected.
        drive(K_RD, 1, 4'hF, 0);
        step();
        check("post-reset READ err_o", 32'(err_o), 32'h1);
        // Storage survives reset: reopen row 3 and read col 1.
        drive(K_ACT, 3, 4'hF, 0);
        step();
        check("post-reset ACT err_o", 32'(err_o), 32'h0);
        drive(K_NOP, 0, 4'hF, 0);
        repeat (4) step();
        drive(K_RD, 1, 4'hF, 0);
        step();
        drive(K_NOP, 0, 4'hF, 0);
        repeat (4) step();
        check("post-reset VALID_o early", 32'(VALID_o), 32'h0);
        step();
        check("post-reset VALID_o", 32'(VALID_o), 32'h1);
        check("post-reset Q_o", Q_o, 32'h000000A1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
